alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Multi-cycle companion to the combinational x86 ALU. Executes MUL, IMUL (one-operand form), DIV and IDIV at 8, 16 or 32-bit operand size.
- Uses iterative radix-2 shift-add and shift-subtract with a start/busy/done handshake.
- Sits beside the main ALU in the execute stage. The sequencer stalls on busy and consumes results on done.

Parameters:
- XLEN, 32, widest operand size: 16 or 32. With XLEN=16, opsize is ignored and treated as 0.

Ports:
- clock, in, 1, system clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-high reset.
- start, in, 1, request pulse; sampled only when busy=0.
- mode, in, 2, operation: 0=MUL, 1=IMUL, 2=DIV, 3=IDIV.
- isize, in, 1, 0 selects 8-bit; 1 selects 16/32-bit per opsize.
- opsize, in, 1, 1 selects 32-bit (when isize=1).
- op1, in, 2*XLEN, packed accumulator pair:
  - 8-bit: AX in [15:0].
  - 16-bit: {DX,AX} in [31:0].
  - 32-bit: {EDX,EAX}.
  - Multiply uses only the low N bits.
- op2, in, XLEN, source operand; low N bits used.
- flags, in, 12, current FLAGS image, same bit layout as the ALU.
- busy, out, 1, operation in progress.
- done, out, 1, one-cycle pulse; results valid.
- exc, out, 1, divide error (#DE); valid with done.
- res_lo, out, XLEN, product low half, or quotient.
- res_hi, out, XLEN, product high half, or remainder.
- flags_o, out, 12, updated flags.

Behaviour:
- N = 8, 16 or 32 from isize/opsize.
- Results are zero-extended above bit N-1.
- 8-bit MUL/IMUL: AX = {res_hi[7:0], res_lo[7:0]}.
- 8-bit DIV: AL = res_lo[7:0], AH = res_hi[7:0].
- Reset:
  - state=IDLE; busy=0, done=0, exc=0.
  - res_lo=0, res_hi=0, flags_o=0.
  - Reset has priority in every state and aborts an operation in progress with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 latches mode, N, operands and flags.
  - For signed modes, also latches the absolute values and the sign of the result and of the remainder.
  - Then: busy=1, counter=N, go to CALC.
- Divide-by-zero fast path: DIV/IDIV with op2[N-1:0]=0 does not enter CALC. At the next edge: done=1, exc=1, busy=0; res_lo/res_hi/flags_o keep their previous values.
- CALC:
  - Performs one bit per cycle for exactly N cycles, then goes to FIX.
  - Multiply: conditional add of the multiplicand, then right shift of a 2N-bit accumulator.
  - Divide: left shift of the 2N-bit remainder, trial subtract, set quotient bit.
- FIX, one cycle:
  - Applies signed negation: quotient negated if the operand signs differ; remainder takes the dividend's sign; product negated if the signs differ.
  - Writes res_lo/res_hi and flags_o.
  - Next edge: done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency: done is high in the cycle N+2 edges after the start edge (10/18/34). The divide-by-zero path takes 1 edge.
- Quotient overflow:
  - DIV: unsigned quotient ≥ 2^N.
  - IDIV: signed quotient outside [-2^(N-1), 2^(N-1)-1].
  - Detected in FIX: exc=1, and res_lo/res_hi/flags_o are not updated.
- Flags:
  - MUL: CF=OF=(high half ≠ 0).
  - IMUL: CF=OF=(high half ≠ sign extension of low half).
  - All other bits are copied from the latched flags.
  - DIV/IDIV: flags_o = latched flags, unchanged.
- start while busy=1 is ignored. Input changes after the start edge have no effect.
- Outputs hold their values after done until the next completed operation.
- start in the same cycle as done is accepted, because busy is already 0 in that cycle.

Test Plan:
- MUL 8-bit, op1=0x0080, op2=0x02 -> res_lo=0x00, res_hi=0x01, flags_o CF=1/OF=1, done exactly 10 edges after start, busy high for 9 of them.
- IMUL 16-bit, op1[15:0]=0xFFFF, op2=0x0005 -> res_hi=0xFFFF, res_lo=0xFFFB, CF=OF=0, done after 18 edges.
- DIV 32-bit, op1=0x00000001_00000000, op2=0x10 -> res_lo=0x10000000, res_hi=0, exc=0, done after 34 edges; flags_o equals flags.
- IDIV 8-bit, op1=0xFF83 (-125), op2=0x07 -> res_lo=0xEF (-17), res_hi=0xFA (-6).
- Divide errors:
  - DIV 16-bit with op2=0 -> done and exc 1 edge after start; outputs retain their previous values.
  - IDIV 8-bit, op1=0x8000, op2=0xFF -> exc=1 after 10 edges.
- Abort and back-to-back:
  - Reset asserted on CALC cycle 5 -> busy=0 next edge, no done.
  - start pulsed while busy -> ignored.
  - start in the done cycle -> new operation starts and its result is correct.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit for MUL, IMUL, DIV and IDIV at 8/16/32-bit operand size.
// Signed operations run on magnitudes. The signs are reapplied and overflow is resolved in a single FIX cycle.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                isize,
    input  logic                opsize,
    input  logic [2*XLEN-1:0]   op1,
    input  logic [XLEN-1:0]     op2,
    input  logic [11:0]         flags,
    output logic                busy,
    output logic                done,
    output logic                exc,
    output logic [XLEN-1:0]     res_lo,
    output logic [XLEN-1:0]     res_hi,
    output logic [11:0]         flags_o
);

    localparam int W  = XLEN;
    localparam int W2 = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [5:0]    n_q, n_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [W-1:0]  mask_q, mask_d;
    logic          neg_q, neg_d;
    logic          rneg_q, rneg_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W2:0]   acc_q, acc_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [11:0]   flags_lat_q, flags_lat_d;
    logic [W-1:0]  res_lo_q, res_lo_d;
    logic [W-1:0]  res_hi_q, res_hi_d;
    logic [11:0]   flags_o_q, flags_o_d;
    logic          done_q, done_d;
    logic          exc_q, exc_d;

    // ---------------- start-time operand decode ----------------
    logic [5:0]    n_in;
    logic [W-1:0]  mask_in, top_in, op2_n, op1_lo, abs2, a1m, rem0, quo0;
    logic [W2-1:0] mask2_in, top2_in, op1_2n, d_abs;
    logic          is_sgn, s1, s2;

    always_comb begin
        n_in     = isize ? (((W == 32) && opsize) ? 6'd32 : 6'd16) : 6'd8;
        mask_in  = {W{1'b1}} >> (W - n_in);
        mask2_in = {W2{1'b1}} >> (W2 - 2 * n_in);
        top_in   = mask_in ^ (mask_in >> 1);
        top2_in  = mask2_in ^ (mask2_in >> 1);
        is_sgn   = mode[0];
        op2_n    = op2 & mask_in;
        op1_lo   = op1[W-1:0] & mask_in;
        op1_2n   = op1 & mask2_in;
        s2       = is_sgn & (|(op2 & top_in));
        s1       = is_sgn & (mode[1] ? (|(op1 & top2_in)) : (|(op1_lo & top_in)));
        abs2     = s2 ? ((-op2_n) & mask_in) : op2_n;
        a1m      = s1 ? ((-op1_lo) & mask_in) : op1_lo;
        d_abs    = s1 ? ((-op1_2n) & mask2_in) : op1_2n;
        rem0     = W'(d_abs >> n_in);
        quo0     = d_abs[W-1:0] & mask_in;
    end

    // ---------------- per-cycle datapath ----------------
    logic [W-1:0]  top_q, mask_hi_sext, p_lo, p_hi, q_res, r_res;
    logic [W2-1:0] mask2_q, prod, prod_s;
    logic [W2:0]   addend, sum;
    logic [W:0]    rem_sh, diff;
    logic          topq, ge, cf, sovf, div_ovf;

    always_comb begin
        top_q   = mask_q ^ (mask_q >> 1);
        mask2_q = {W2{1'b1}} >> (W2 - 2 * n_q);
        // The multiplicand is added at bit N of the accumulator, so one datapath serves all three sizes.
        addend  = {{(W+1){1'b0}}, mcand_q} << n_q;
        sum     = acc_q[0] ? (acc_q + addend) : acc_q;
        topq    = |(quo_q & top_q);
        rem_sh  = {rem_q, topq};
        diff    = rem_sh - {1'b0, mcand_q};
        ge      = (rem_sh >= {1'b0, mcand_q});

        prod         = acc_q[W2-1:0];
        prod_s       = neg_q ? ((-prod) & mask2_q) : prod;
        p_lo         = prod_s[W-1:0] & mask_q;
        p_hi         = W'(prod_s >> n_q);
        mask_hi_sext = (|(p_lo & top_q)) ? mask_q : '0;
        cf           = mode_q[0] ? (p_hi != mask_hi_sext) : (p_hi != '0);

        // Magnitudes are below 2^N unless ovf_q is set. A negative quotient may reach exactly 2^(N-1).
        sovf    = neg_q ? (quo_q > top_q) : (quo_q >= top_q);
        div_ovf = ovf_q | (mode_q[0] & sovf);
        q_res   = neg_q ? ((-quo_q) & mask_q) : quo_q;
        r_res   = rneg_q ? ((-rem_q) & mask_q) : rem_q;
    end

    // ---------------- control ----------------
    always_comb begin
        // NOTE: every next-state signal takes its held value first, so no path through the case infers a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        ovf_d       = ovf_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        flags_lat_d = flags_lat_q;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        flags_o_d   = flags_o_q;
        done_d      = 1'b0;
        exc_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mode[1] && (op2_n == '0)) begin
                        done_d = 1'b1;
                        exc_d  = 1'b1;
                    end else begin
                        mode_d      = mode;
                        n_d         = n_in;
                        cnt_d       = n_in;
                        mask_d      = mask_in;
                        flags_lat_d = flags;
                        neg_d       = s1 ^ s2;
                        rneg_d      = s1;
                        mcand_d     = abs2;
                        acc_d       = {{(W+1){1'b0}}, a1m};
                        rem_d       = rem0;
                        quo_d       = quo0;
                        ovf_d       = mode[1] & (rem0 >= abs2);
                        state_d     = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (mode_q[1]) begin
                    rem_d = ge ? diff[W-1:0] : rem_sh[W-1:0];
                    quo_d = ((quo_q << 1) | {{(W-1){1'b0}}, ge}) & mask_q;
                end else begin
                    acc_d = sum >> 1;
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (mode_q[1]) begin
                    exc_d = div_ovf;
                    if (!div_ovf) begin
                        res_lo_d  = q_res;
                        res_hi_d  = r_res;
                        flags_o_d = flags_lat_q;
                    end
                end else begin
                    res_lo_d  = p_lo;
                    res_hi_d  = p_hi;
                    flags_o_d = {cf, flags_lat_q[10:1], cf};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every register samples the values from before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            n_q         <= 6'd8;
            cnt_q       <= '0;
            mask_q      <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            ovf_q       <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            flags_lat_q <= '0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            flags_o_q   <= '0;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            ovf_q       <= ovf_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            flags_lat_q <= flags_lat_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
            flags_o_q   <= flags_o_d;
            done_q      <= done_d;
            exc_q       <= exc_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign exc     = exc_q;
    assign res_lo  = res_lo_q;
    assign res_hi  = res_hi_q;
    assign flags_o = flags_o_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: results, flags, latency, divide errors, abort, and start handling.
module tb_alu_muldiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic        isize = 1'b0;
    logic        opsize = 1'b0;
    logic [63:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [11:0] flags = '0;
    logic        busy, done, exc;
    logic [31:0] res_lo, res_hi;
    logic [11:0] flags_o;

    int errors = 0;
    int checks = 0;
    int edges, busy_cycles;
    bit saw_done;

    alu_muldiv #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .isize(isize), .opsize(opsize), .op1(op1), .op2(op2), .flags(flags),
        .busy(busy), .done(done), .exc(exc),
        .res_lo(res_lo), .res_hi(res_hi), .flags_o(flags_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1. Drives one start pulse and scrambles the inputs after the start edge.
    // Returns once done is observed, or after a bound of 100 edges.
    task automatic run_op(input logic [1:0] m, input logic isz, input logic osz,
                          input logic [63:0] a, input logic [31:0] b, input logic [11:0] f);
        mode = m; isize = isz; opsize = osz; op1 = a; op2 = b; flags = f; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        op1 = ~a; op2 = b ^ 32'h5A5A_A5A5; flags = ~f; mode = ~m;
        edges = 1;
        busy_cycles = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(posedge clock); #1;
            edges++;
            if (busy) busy_cycles++;
        end
    endtask

    initial begin
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_exc", exc, 0);
        check("rst_lo", res_lo, 0);
        check("rst_hi", res_hi, 0);
        check("rst_flags", flags_o, 0);

        // MUL 8-bit: 0x80 * 0x02 = 0x0100
        run_op(2'd0, 1'b0, 1'b0, 64'h0080, 32'h02, 12'h000);
        check("mul8_edges", edges, 10);
        check("mul8_busy", busy_cycles, 9);
        check("mul8_lo", res_lo, 32'h00);
        check("mul8_hi", res_hi, 32'h01);
        check("mul8_flags", flags_o, 12'h801);
        check("mul8_exc", exc, 0);
        @(posedge clock); #1;
        check("mul8_pulse", done, 0);
        check("mul8_hold", res_hi, 32'h01);

        // IMUL 16-bit: -1 * 5 = -5. Incoming CF/OF are cleared and the other bits pass through.
        run_op(2'd1, 1'b1, 1'b0, 64'h0000_FFFF, 32'h0005, 12'h8C5);
        check("imul16_edges", edges, 18);
        check("imul16_lo", res_lo, 32'hFFFB);
        check("imul16_hi", res_hi, 32'hFFFF);
        check("imul16_flags", flags_o, 12'h0C4);

        // DIV 32-bit: 2^32 / 16
        run_op(2'd2, 1'b1, 1'b1, 64'h0000_0001_0000_0000, 32'h10, 12'h0D5);
        check("div32_edges", edges, 34);
        check("div32_lo", res_lo, 32'h1000_0000);
        check("div32_hi", res_hi, 32'h0);
        check("div32_exc", exc, 0);
        check("div32_flags", flags_o, 12'h0D5);

        // IDIV 8-bit: -125 / 7 = -17 remainder -6
        run_op(2'd3, 1'b0, 1'b0, 64'hFF83, 32'h07, 12'h044);
        check("idiv8_edges", edges, 10);
        check("idiv8_lo", res_lo, 32'hEF);
        check("idiv8_hi", res_hi, 32'hFA);
        check("idiv8_flags", flags_o, 12'h044);

        // DIV 16-bit by zero. Only the low 16 bits of op2 count, so the nonzero upper bits are ignored.
        run_op(2'd2, 1'b1, 1'b0, 64'h1234, 32'hABCD_0000, 12'hFFF);
        check("dz_edges", edges, 1);
        check("dz_exc", exc, 1);
        check("dz_busy", busy, 0);
        check("dz_lo", res_lo, 32'hEF);
        check("dz_hi", res_hi, 32'hFA);
        check("dz_flags", flags_o, 12'h044);

        // IDIV 8-bit: -32768 / -1 overflows
        run_op(2'd3, 1'b0, 1'b0, 64'h8000, 32'hFF, 12'h000);
        check("iovf_edges", edges, 10);
        check("iovf_exc", exc, 1);
        check("iovf_lo", res_lo, 32'hEF);
        check("iovf_flags", flags_o, 12'h044);

        // Reset in CALC cycle 5 aborts with no done pulse.
        mode = 2'd0; isize = 1'b1; opsize = 1'b1; op1 = 64'h1234_5678; op2 = 32'h9; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        check("abort_busy_pre", busy, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin @(posedge clock); #1; if (done) saw_done = 1'b1; end
        check("abort_no_done", saw_done, 0);
        check("abort_lo", res_lo, 0);

        // A start pulse while busy (a divide by zero) is ignored.
        mode = 2'd0; isize = 1'b0; opsize = 1'b0; op1 = 64'h0003; op2 = 32'h05; flags = 12'h000; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; edges = 1;
        repeat (2) begin @(posedge clock); #1; edges++; end
        mode = 2'd2; op2 = 32'h0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; edges++;
        while (!done && edges < 100) begin @(posedge clock); #1; edges++; end
        check("ign_edges", edges, 10);
        check("ign_exc", exc, 0);
        check("ign_lo", res_lo, 32'h0F);

        // A start in the done cycle is accepted: MUL 16 0x1234 * 0x0100.
        run_op(2'd0, 1'b1, 1'b0, 64'h1234, 32'h0100, 12'h000);
        check("b2b_edges", edges, 18);
        check("b2b_lo", res_lo, 32'h3400);
        check("b2b_hi", res_hi, 32'h0012);
        check("b2b_flags", flags_o, 12'h801);

        // IMUL 32-bit: (-2^31)^2 = 2^62
        run_op(2'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 12'h000);
        check("imul32_edges", edges, 34);
        check("imul32_lo", res_lo, 32'h0);
        check("imul32_hi", res_hi, 32'h4000_0000);
        check("imul32_flags", flags_o, 12'h801);

        // DIV 8-bit: 0x200 / 2 gives a quotient of 256, which overflows.
        run_op(2'd2, 1'b0, 1'b0, 64'h0200, 32'h02, 12'h000);
        check("dovf_exc", exc, 1);
        check("dovf_hi", res_hi, 32'h4000_0000);

        // IDIV 8-bit: -128 / 1 = -128, which is the lowest quotient that does not overflow.
        run_op(2'd3, 1'b0, 1'b0, 64'hFF80, 32'h01, 12'h000);
        check("imin_exc", exc, 0);
        check("imin_lo", res_lo, 32'h80);
        check("imin_hi", res_hi, 32'h00);
        check("imin_flags", flags_o, 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
